vga_sync_gen: RTL and testbench

// - Timing source for the VGA path. Produces the raster position (hCount, vCount),
//   the blanking flag (bright) and the active-low hSync/vSync pins.
// - The pixel generator consumes hCount/vCount/bright and produces rgb for the

---
 rtl/vga_sync_gen.sv | 172 +++++++++++++++++
 tb/tb_vga_sync_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing source for the VGA path.
// A pixel-rate divider paces two four-phase machines (horizontal and
// vertical). The raster counters, the sync/blank decodes and the frame
// tick/counter are all updated on the same clock edge. As a result, every
// output describes the position that is on hCount/vCount at that moment.
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        rst_l,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  // Last position of each phase. A phase hands over to the next phase on the
  // pixel that follows its last position.
  localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] H_BACK_LAST = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_ACT_LAST  = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
  localparam logic [9:0] V_BACK_LAST = 10'(V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

  // The divider keeps at least one bit, so that CLK_DIV=1 still elaborates.
  // In that case the divider simply stays at 0 and ticks on every clock.
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    H_SYNC_PH,
    H_BACK_PH,
    H_ACT_PH,
    H_FRONT_PH
  } h_phase_t;

  typedef enum logic [1:0] {
    V_SYNC_PH,
    V_BACK_PH,
    V_ACT_PH,
    V_FRONT_PH
  } v_phase_t;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  h_phase_t         h_phase;
  h_phase_t         h_phase_next;
  v_phase_t         v_phase;
  v_phase_t         v_phase_next;
  logic [9:0]       h_count_next;
  logic [9:0]       v_count_next;
  logic             line_end;
  logic             frame_end;

  // Pixel strobe: this is the clock on which the whole raster advances by one pixel.
  assign tick = (div_cnt == DIV_LAST);

  // Pixel-rate divider: counts modulo CLK_DIV. pix_en is registered, so it is
  // high during the clock that shows the newly advanced position.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so that every
      // flop samples the pre-edge values, independent of statement order.
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      pix_en  <= tick;
    end
  end

  // Next-state logic for both phase machines and both raster counters. The
  // vertical side moves only on the last pixel of a line.
  always_comb begin
    // NOTE: every signal is given a hold value before any branch, so that no
    // path can leave one unassigned and infer a latch.
    h_phase_next = h_phase;
    v_phase_next = v_phase;
    h_count_next = hCount;
    v_count_next = vCount;
    line_end     = 1'b0;
    frame_end    = 1'b0;

    if (tick) begin
      line_end     = (hCount == H_LAST);
      h_count_next = line_end ? 10'd0 : hCount + 10'd1;

      unique case (h_phase)
        H_SYNC_PH:  if (hCount == H_SYNC_LAST) h_phase_next = H_BACK_PH;
        H_BACK_PH:  if (hCount == H_BACK_LAST) h_phase_next = H_ACT_PH;
        H_ACT_PH:   if (hCount == H_ACT_LAST)  h_phase_next = H_FRONT_PH;
        H_FRONT_PH: if (line_end)              h_phase_next = H_SYNC_PH;
        default:                               h_phase_next = H_SYNC_PH;
      endcase

      if (line_end) begin
        frame_end    = (vCount == V_LAST);
        v_count_next = frame_end ? 10'd0 : vCount + 10'd1;

        unique case (v_phase)
          V_SYNC_PH:  if (vCount == V_SYNC_LAST) v_phase_next = V_BACK_PH;
          V_BACK_PH:  if (vCount == V_BACK_LAST) v_phase_next = V_ACT_PH;
          V_ACT_PH:   if (vCount == V_ACT_LAST)  v_phase_next = V_FRONT_PH;
          V_FRONT_PH: if (frame_end)             v_phase_next = V_SYNC_PH;
          default:                               v_phase_next = V_SYNC_PH;
        endcase
      end
    end
  end

  // Phase and counter registers. After reset the raster sits at (0,0), which
  // is inside the sync phase of both axes.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      h_phase <= H_SYNC_PH;
      v_phase <= V_SYNC_PH;
      hCount  <= 10'd0;
      vCount  <= 10'd0;
    end else begin
      h_phase <= h_phase_next;
      v_phase <= v_phase_next;
      hCount  <= h_count_next;
      vCount  <= v_count_next;
    end
  end

  // Registered decodes, taken from the next phase. This keeps them aligned
  // with the counter values that are loaded on the same edge.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      hSync  <= 1'b0;
      vSync  <= 1'b0;
      bright <= 1'b0;
    end else begin
      hSync  <= (h_phase_next != H_SYNC_PH);
      vSync  <= (v_phase_next != V_SYNC_PH);
      bright <= (h_phase_next == H_ACT_PH) && (v_phase_next == V_ACT_PH);
    end
  end

  // Frame tick and frame counter. Both fire on the edge that wraps vCount to
  // 0. The counter rolls over from 65535 to 0.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      frame_tick  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_tick <= frame_end;
      if (frame_end) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: self-checking bench for vga_sync_gen.
// The bench runs three instances side by side:
//   A - default 640x480 timing with CLK_DIV=4.
//   B - a scaled raster with CLK_DIV=3.
//   C - a tiny raster with CLK_DIV=1.
// Expected outputs come from a closed-form model. The model derives the raster
// position from the number of clocks elapsed since reset release. The bench
// also inserts random asynchronous resets part-way through a frame.
module tb_vga_sync_gen;

  typedef struct packed {
    logic        pix_en;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        br;
    logic        ft;
    logic [15:0] fc;
  } vga_t;

  logic   clk = 1'b0;
  logic   rst_l;
  longint n = 0;           // clock edges since the last reset release
  int     n_checks = 0;
  int     n_errors = 0;
  bit     cmp_on = 1'b0;
  bit     phase1 = 1'b0;
  int     c_bright = 0;
  int     b_ticks = 0;
  bit     seen   [800];
  bit     hs_low [800];

  always #5 clk = ~clk;

  // Clock-since-release counter. It is cleared asynchronously together with the DUTs.
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) n <= 0;
    else        n <= n + 1;
  end

  // DUT instances
  logic a_pe, a_hs, a_vs, a_br, a_ft; logic [9:0] a_h, a_v; logic [15:0] a_fc;
  logic b_pe, b_hs, b_vs, b_br, b_ft; logic [9:0] b_h, b_v; logic [15:0] b_fc;
  logic c_pe, c_hs, c_vs, c_br, c_ft; logic [9:0] c_h, c_v; logic [15:0] c_fc;
  vga_t out_a, out_b, out_c;
  assign out_a = '{a_pe, a_h, a_v, a_hs, a_vs, a_br, a_ft, a_fc};
  assign out_b = '{b_pe, b_h, b_v, b_hs, b_vs, b_br, b_ft, b_fc};
  assign out_c = '{c_pe, c_h, c_v, c_hs, c_vs, c_br, c_ft, c_fc};

  vga_sync_gen u_a (
    .clk(clk), .rst_l(rst_l), .pix_en(a_pe), .hCount(a_h), .vCount(a_v),
    .hSync(a_hs), .vSync(a_vs), .bright(a_br), .frame_tick(a_ft), .frame_count(a_fc));

  vga_sync_gen #(
    .CLK_DIV(3), .H_SYNC(8), .H_BACK(4), .H_ACTIVE(16), .H_FRONT(4),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(8), .V_FRONT(2)
  ) u_b (
    .clk(clk), .rst_l(rst_l), .pix_en(b_pe), .hCount(b_h), .vCount(b_v),
    .hSync(b_hs), .vSync(b_vs), .bright(b_br), .frame_tick(b_ft), .frame_count(b_fc));

  vga_sync_gen #(
    .CLK_DIV(1), .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1)
  ) u_c (
    .clk(clk), .rst_l(rst_l), .pix_en(c_pe), .hCount(c_h), .vCount(c_v),
    .hSync(c_hs), .vSync(c_vs), .bright(c_br), .frame_tick(c_ft), .frame_count(c_fc));

  // Closed-form raster model. After n clocks the raster has advanced n/d
  // pixels. Position, sync windows and frame count follow from plain
  // division and modulo arithmetic.
  function automatic vga_t model(input int d, input int hs, input int hb, input int ha,
                                 input int hf, input int vs, input int vb, input int va,
                                 input int vf, input longint cnt);
    longint ht = hs + hb + ha + hf;
    longint vt = vs + vb + va + vf;
    longint fl = ht * vt;
    longint p  = cnt / d;
    longint h  = p % ht;
    longint v  = (p / ht) % vt;
    vga_t   r;
    r.pix_en = (cnt > 0) && (cnt % d == 0);
    r.h      = 10'(h);
    r.v      = 10'(v);
    r.hs     = (h >= hs);
    r.vs     = (v >= vs);
    r.br     = (h >= hs + hb) && (h < hs + hb + ha) && (v >= vs + vb) && (v < vs + vb + va);
    r.ft     = r.pix_en && (p > 0) && (p % fl == 0);
    r.fc     = 16'((p / fl) % 65536);
    return r;
  endfunction

  function automatic vga_t exp_a(input longint cnt);
    return model(4, 96, 48, 640, 16, 2, 33, 480, 10, cnt);
  endfunction
  function automatic vga_t exp_b(input longint cnt);
    return model(3, 8, 4, 16, 4, 2, 3, 8, 2, cnt);
  endfunction
  function automatic vga_t exp_c(input longint cnt);
    return model(1, 2, 2, 4, 2, 1, 1, 3, 1, cnt);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bounded wait until the since-release counter reaches target.
  task automatic wait_n(input longint target);
    int k = 0;
    while (n < target && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (n != target) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_n: reached n=%0d expected %0d", n, target);
    end
  endtask

  // Per-cycle comparison of every instance against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check($sformatf("A n=%0d", n), 64'(out_a), 64'(exp_a(n)));
      check($sformatf("B n=%0d", n), 64'(out_b), 64'(exp_b(n)));
      check($sformatf("C n=%0d", n), 64'(out_c), 64'(exp_c(n)));
    end
  end

  // Bookkeeping for the line and frame summary checks.
  always @(negedge clk) begin
    if (phase1 && rst_l) begin
      if (a_v == 10'd0 && a_h < 10'd800) begin
        seen[a_h]   = 1'b1;
        hs_low[a_h] = !a_hs;
      end
      if (n >= 1 && n <= 180 && c_br) c_bright++;
    end
    if (rst_l && b_ft) b_ticks++;
  end

  initial begin
    vga_t m;
    int   cnt_seen;
    int   cnt_low;

    // Hand-computed values that pin the model itself.
    m = exp_a(4);
    check("model A n=4 {pe,h}", 64'({m.pix_en, m.h}), 64'({1'b1, 10'd1}));
    m = exp_a(3200);
    check("model A n=3200 {h,v}", 64'({m.h, m.v}), 64'({10'd0, 10'd1}));
    m = exp_c(180);
    check("model C n=180 fc", 64'(m.fc), 64'(16'd3));
    m = exp_b(1440);
    check("model B n=1440 {ft,fc}", 64'({m.ft, m.fc}), 64'({1'b1, 16'd1}));

    rst_l = 1'b0;
    repeat (3) @(negedge clk);
    check("reset A", 64'(out_a), 64'(0));
    check("reset B", 64'(out_b), 64'(0));
    check("reset C", 64'(out_c), 64'(0));
    cmp_on = 1'b1;
    phase1 = 1'b1;
    #1 rst_l = 1'b1;

    // First pixel strobe of A arrives 4 clocks after release.
    wait_n(3);
    check("A n=3 {pe,h}", 64'({a_pe, a_h}), 64'({1'b0, 10'd0}));
    wait_n(4);
    check("A n=4 {pe,h}", 64'({a_pe, a_h}), 64'({1'b1, 10'd1}));
    wait_n(5);
    check("A n=5 {pe,h}", 64'({a_pe, a_h}), 64'({1'b0, 10'd1}));
    wait_n(8);
    check("A n=8 {pe,h}", 64'({a_pe, a_h}), 64'({1'b1, 10'd2}));

    // Three full frames of C: 3 x (4 x 3) bright pixels.
    wait_n(181);
    check("C frame_count after 3 frames", 64'(c_fc), 64'(16'd3));
    check("C bright pixels in 3 frames", 64'(c_bright), 64'(36));

    // End of the first line of A.
    wait_n(3200);
    check("A line wrap {h,v}", 64'({a_h, a_v}), 64'({10'd0, 10'd1}));
    check("B frame_count n=3200", 64'(b_fc), 64'(16'd2));
    phase1 = 1'b0;
    cnt_seen = 0;
    cnt_low  = 0;
    for (int i = 0; i < 800; i++) begin
      cnt_seen += int'(seen[i]);
      cnt_low  += int'(hs_low[i]);
    end
    check("A line0 positions seen", 64'(cnt_seen), 64'(800));
    check("A line0 hSync low count", 64'(cnt_low), 64'(96));
    check("A hSync at 95/96", 64'({hs_low[95], hs_low[96]}), 64'(2'b10));

    // Random asynchronous resets at arbitrary raster positions.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(100, 1500)) @(negedge clk);
      #2 rst_l = 1'b0;
      #1;
      check($sformatf("async reset %0d A", r), 64'(out_a), 64'(0));
      check($sformatf("async reset %0d B", r), 64'(out_b), 64'(0));
      check($sformatf("async reset %0d C", r), 64'(out_c), 64'(0));
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1 rst_l = 1'b1;
      b_ticks = 0;
    end

    // After the last release, B must not tick until one full frame has elapsed.
    wait_n(1439);
    check("B no tick before full frame", 64'(b_ticks), 64'(0));
    wait_n(1440);
    check("B frame boundary {ft,fc,h,v}", 64'({b_ft, b_fc, b_h, b_v}),
          64'({1'b1, 16'd1, 10'd0, 10'd0}));
    wait_n(1441);
    check("B tick is one clock", 64'(b_ft), 64'(0));
    wait_n(1450);
    check("B ticks in first frame", 64'(b_ticks), 64'(1));

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
